lock_door_sequencer: RTL and testbench

//  Master controller for a two-door canal lock chamber. Issues one-cycle open/close

---
 rtl/lock_door_sequencer_if.sv | 31 +++
 rtl/lock_door_sequencer.sv | 154 +++++++++++++++
 tb/tb_lock_door_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lock_door_sequencer_if.sv
// Bundle between the lock chamber sequencer and its door units / request
// panels.
//   master : the sequencer. It reads the requests and door status, and drives
//            the door command pulses and the chamber status.
//   slave  : the door units and panels, with the directions reversed.
interface lock_door_sequencer_if;
  logic req_in;        // boat at outer side wants to go inward
  logic req_out;       // boat at inner side wants to go outward
  logic boat_clear;    // boat has passed the open door
  logic outer_status;  // 1 = outer door closed
  logic inner_status;  // 1 = inner door closed
  logic outer_open;    // command pulses
  logic outer_close;
  logic inner_open;
  logic inner_close;
  logic level_high;    // 1 = chamber level matches the inner side
  logic busy;
  logic fault;

  modport master (
    input  req_in, req_out, boat_clear, outer_status, inner_status,
    output outer_open, outer_close, inner_open, inner_close,
           level_high, busy, fault
  );

  modport slave (
    output req_in, req_out, boat_clear, outer_status, inner_status,
    input  outer_open, outer_close, inner_open, inner_close,
           level_high, busy, fault
  );
endinterface

// File: rtl/lock_door_sequencer.sv
// Master controller for a two-door canal lock chamber.
// It serves one passage at a time. A passage runs these steps:
//   1. Level the water to the entry side.
//   2. Open the entry door.
//   3. Wait for the boat.
//   4. Close the entry door.
//   5. Level the water to the exit side.
//   6. Open the exit door, wait for the boat, then close the exit door.
// The two doors are never open together. Any door that does not move in
// time, and any observation of both doors open, latches FAULT. Only reset
// leaves FAULT.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : lock_door_sequencer_if.master. It carries the requests,
//           boat_clear, the door status, the door commands, level_high,
//           busy and fault.
module lock_door_sequencer #(
  parameter int FILL_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  lock_door_sequencer_if.master  bus
);

  localparam int MAXC = (FILL_CYCLES > TIMEOUT_CYCLES) ? FILL_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    IDLE, LEVEL_ENTRY, OPEN_ENTRY, PASS_ENTRY, CLOSE_ENTRY,
    LEVEL_EXIT, OPEN_EXIT, PASS_EXIT, CLOSE_EXIT, FAULT
  } state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;      // 0 = inward (enter at outer), 1 = outward
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic is_exit, side, tgt_st, oth_st, counting;
  logic o_open, o_close, i_open, i_close;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    level_d  = level_q;
    o_open   = 1'b0;
    o_close  = 1'b0;
    i_open   = 1'b0;
    i_close  = 1'b0;
    counting = 1'b0;

    // The door being worked on: entry side = dir, exit side = !dir (1 = inner).
    // The level matches a side when level_high equals that side bit.
    is_exit = (state_q == LEVEL_EXIT) || (state_q == OPEN_EXIT) ||
              (state_q == PASS_EXIT)  || (state_q == CLOSE_EXIT);
    side    = dir_q ^ is_exit;
    tgt_st  = side ? bus.inner_status : bus.outer_status;
    oth_st  = side ? bus.outer_status : bus.inner_status;

    case (state_q)
      IDLE: begin
        // When the level already matches, go straight to OPEN. The open pulse
        // then appears in the cycle after the request is sampled.
        if (bus.req_in) begin
          dir_d   = 1'b0;
          state_d = (level_q == 1'b0) ? OPEN_ENTRY : LEVEL_ENTRY;
        end else if (bus.req_out) begin
          dir_d   = 1'b1;
          state_d = (level_q == 1'b1) ? OPEN_ENTRY : LEVEL_ENTRY;
        end
      end
      LEVEL_ENTRY, LEVEL_EXIT: begin
        counting = 1'b1;
        if (cnt_q == CW'(FILL_CYCLES - 1)) begin
          level_d = ~level_q;
          state_d = is_exit ? OPEN_EXIT : OPEN_ENTRY;
        end
      end
      OPEN_ENTRY, OPEN_EXIT: begin
        counting = 1'b1;
        // Command the open only if the other door reports closed. If no pulse
        // is sent, the wait below times out into FAULT.
        if (cnt_q == '0 && oth_st) begin
          o_open = ~side;
          i_open = side;
        end
        if (!tgt_st)
          state_d = is_exit ? PASS_EXIT : PASS_ENTRY;
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1))
          state_d = FAULT;
      end
      PASS_ENTRY, PASS_EXIT: begin
        if (bus.boat_clear)
          state_d = is_exit ? CLOSE_EXIT : CLOSE_ENTRY;
      end
      CLOSE_ENTRY, CLOSE_EXIT: begin
        counting = 1'b1;
        if (cnt_q == '0) begin
          o_close = ~side;
          i_close = side;
        end
        if (tgt_st) begin
          if (is_exit)
            state_d = IDLE;
          else
            state_d = (level_q == ~dir_q) ? OPEN_EXIT : LEVEL_EXIT;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        o_close = 1'b1;
        i_close = 1'b1;
      end
      default: state_d = FAULT;
    endcase

    // Interlock: both doors open overrides the normal next state.
    if (state_q != FAULT && !bus.outer_status && !bus.inner_status)
      state_d = FAULT;

    // Every state change restarts the timer.
    if (state_d != state_q)
      cnt_d = '0;
    else if (counting)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  assign bus.outer_open  = o_open;
  assign bus.outer_close = o_close;
  assign bus.inner_open  = i_open;
  assign bus.inner_close = i_close;
  assign bus.level_high  = level_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.fault       = (state_q == FAULT);

endmodule

// File: tb/tb_lock_door_sequencer.sv
// Directed bench for lock_door_sequencer. It contains a simple door model.
// A close command wins over an open command. A door's status follows the
// command one cycle after the command pulse.
module tb_lock_door_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic freeze = 1'b0;
  int   n;

  lock_door_sequencer_if bus ();

  lock_door_sequencer #(.FILL_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock. Commands are sampled mid-cycle. Door status is applied #1
  // after the edge.
  task automatic tick();
    logic oo, oc, io, ic;
    @(negedge clk);
    oo = bus.outer_open; oc = bus.outer_close;
    io = bus.inner_open; ic = bus.inner_close;
    @(posedge clk);
    #1;
    if (!freeze) begin
      if (oc) bus.outer_status = 1'b1; else if (oo) bus.outer_status = 1'b0;
      if (ic) bus.inner_status = 1'b1; else if (io) bus.inner_status = 1'b0;
    end
  endtask

  // Advance until the selected output is high, within a bounded number of ticks.
  // Selector: 0 = outer_open, 2 = inner_open, 5 = fault.
  task automatic run_until(input int which, input int bound, output int cnt);
    logic s;
    cnt = 0;
    forever begin
      case (which)
        0: s = bus.outer_open;
        2: s = bus.inner_open;
        default: s = bus.fault;
      endcase
      if (s || cnt >= bound) break;
      tick();
      cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_in = 0; bus.req_out = 0; bus.boat_clear = 0;
    bus.outer_status = 1; bus.inner_status = 1;
    freeze = 0;
    @(posedge clk); #1;
    chk("rst_cmds", {bus.outer_open, bus.outer_close, bus.inner_open, bus.inner_close}, 0);
    chk("rst_level", bus.level_high, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fault", bus.fault, 0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset state, then stay idle after release.
    do_reset();
    tick(); tick();
    chk("idle_held_busy", bus.busy, 0);
    chk("idle_held_cmds", {bus.outer_open, bus.outer_close, bus.inner_open, bus.inner_close}, 0);

    // 2: full inward passage starting at low level.
    bus.req_in = 1; tick(); bus.req_in = 0;
    chk("t2_outer_open_lat", bus.outer_open, 1);
    chk("t2_busy", bus.busy, 1);
    tick();
    chk("t2_open_one_cycle", bus.outer_open, 0);
    chk("t2_outer_opened", bus.outer_status, 0);
    tick();                                    // enters PASS_ENTRY
    chk("t2_no_close_yet", bus.outer_close, 0);
    bus.boat_clear = 1; tick(); bus.boat_clear = 0;
    chk("t2_outer_close", bus.outer_close, 1);
    tick();
    chk("t2_close_one_cycle", bus.outer_close, 0);
    tick();                                    // enters LEVEL_EXIT
    chk("t2_level_before", bus.level_high, 0);
    run_until(2, 30, n);
    chk("t2_fill_cycles", n, 8);
    chk("t2_level_after", bus.level_high, 1);
    chk("t2_no_outer_during", bus.outer_open, 0);
    tick(); tick();                            // door opens, PASS_EXIT
    bus.boat_clear = 1; tick(); bus.boat_clear = 0;
    chk("t2_inner_close", bus.inner_close, 1);
    tick(); tick();
    chk("t2_done_busy", bus.busy, 0);
    chk("t2_done_level", bus.level_high, 1);

    // 3: both requests together. Inward wins; the level must drain first.
    bus.req_in = 1; bus.req_out = 1; tick(); bus.req_in = 0;
    chk("t3_busy", bus.busy, 1);
    chk("t3_no_open_yet", {bus.outer_open, bus.inner_open}, 0);
    run_until(0, 30, n);
    chk("t3_drain_cycles", n, 8);
    chk("t3_outer_first", {bus.outer_open, bus.inner_open}, 2'b10);
    chk("t3_level_low", bus.level_high, 0);
    tick(); tick();
    bus.boat_clear = 1; tick(); bus.boat_clear = 0;
    tick(); tick();
    run_until(2, 30, n);
    chk("t3_fill_cycles", n, 8);
    tick(); tick();
    bus.boat_clear = 1; tick(); bus.boat_clear = 0;
    tick(); tick();
    chk("t3_req_out_ignored", bus.busy, 0);
    bus.req_out = 0;
    tick();
    chk("t3_stays_idle", bus.busy, 0);

    // 4: frozen doors. The open times out into FAULT.
    freeze = 1;
    bus.req_out = 1; tick(); bus.req_out = 0;  // level high, so inner opens at once
    chk("t4_inner_open", bus.inner_open, 1);
    run_until(5, 40, n);
    chk("t4_timeout_cycles", n, 16);
    chk("t4_closes_held", {bus.outer_close, bus.inner_close}, 2'b11);
    tick(); tick(); tick();
    chk("t4_fault_sticky", bus.fault, 1);
    chk("t4_closes_still", {bus.outer_close, bus.inner_close, bus.outer_open, bus.inner_open}, 4'b1100);
    chk("t4_busy", bus.busy, 1);

    // 5: interlock. Inner reports open while outer is open.
    do_reset();
    bus.req_in = 1; tick(); bus.req_in = 0;
    tick(); tick();                            // outer open, PASS_ENTRY
    bus.inner_status = 0;
    chk("t5_not_yet", bus.fault, 0);
    tick();
    chk("t5_interlock_fault", bus.fault, 1);

    // 6: reset during a fill aborts immediately.
    do_reset();
    bus.req_out = 1; tick(); bus.req_out = 0;  // LEVEL_ENTRY, fill cycle 1
    tick(); tick(); tick();                    // fill cycle 4
    chk("t6_filling", bus.busy, 1);
    #2 reset = 1; #1;
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_level", bus.level_high, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_pulses", {bus.outer_open, bus.outer_close, bus.inner_open, bus.inner_close}, 0);
    end
    reset = 0;
    tick();
    chk("t6_idle_after", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
